magnetron_control: RTL and testbench
====================================

// Module: magnetron_control
// PURPOSE
//  Parametrised successor of the single-bit oven control: drives the magnetron with selectable power
//  (duty-cycle modulation over a fixed window), supports pause/resume and a timed end-of-cook beep.
//  Sits between the keypad/door inputs and the cook timer; timer_en gates the timer countdown.
// PARAMETERS
//  LEVELS      4   number of power levels; power_level 0..LEVELS-1
//  PERIOD      8   duty window length in clk cycles (PERIOD >= LEVELS)
//  BEEP_CYCLES 16  cycles beep stays high after cook completes
//  LVL_W       2   width of power_level, = clog2(LEVELS)
// PORTS
//  clk          in   1      system clock, rising edge
//  resetn       in   1      asynchronous, active-low reset
//  startn       in   1      start button, active low (level; falling edge used)
//  stopn        in   1      stop/pause button, active low (falling edge used)
//  clearn       in   1      clear, active low (level)
//  door_closed  in   1      1 = door closed
//  timer_done   in   1      cook timer reached zero (level)
//  power_level  in   LVL_W  requested power; values >= LEVELS treated as LEVELS-1
//  magnetron_on out  1      magnetron drive (replaces Q)
//  timer_en     out  1      enable for cook timer countdown
//  beep         out  1      end-of-cook indicator
//  state        out  2      IDLE=00 RUN=01 PAUSE=10 DONE=11
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE, phase=0, beep cnt=0, lvl_q=0, startn_q=stopn_q=1;
//   all outputs 0. Outputs decode registers only; no input-to-output combinational path.
//  Edge detect: start_evt = ~startn & startn_q; stop_evt = ~stopn & stopn_q (prev-cycle regs).
//  Per-edge priority: clearn=0 > stop_evt > timer_done > door open > start_evt.
//  IDLE : start_evt & door_closed & ~timer_done -> RUN, lvl_q<=clamped power_level, phase<=0.
//  RUN  : clearn=0 -> IDLE; stop_evt -> PAUSE; timer_done -> DONE (beep cnt<=BEEP_CYCLES);
//         ~door_closed -> PAUSE; else phase<=(phase==PERIOD-1)?0:phase+1.
//  PAUSE: clearn=0 or stop_evt -> IDLE (second stop cancels); start_evt & door_closed & ~timer_done
//         -> RUN, phase<=0, lvl_q re-sampled. Door opening in PAUSE: stay PAUSE.
//  DONE : clearn=0 -> IDLE; else beep cnt decrements, -> IDLE when it reaches 1. start ignored.
//  on_cycles = ((lvl_q+1)*PERIOD)/LEVELS, integer floor; defaults give 2,4,6,8.
//  magnetron_on = (state==RUN) & (phase < on_cycles); high in first RUN cycle (phase 0).
//  timer_en = (state==RUN) for whole window regardless of duty phase.
//  beep = (state==DONE): high exactly BEEP_CYCLES cycles.
//  Transitions take effect on the clk edge sampling the event (1-cycle latency from input).
//  Held startn low does not restart after stop/pause; needs a new falling edge.
//  power_level changes during RUN ignored until next RUN entry.
//  Reset mid-RUN: magnetron_on drops immediately (async), no beep.
// TESTING
//  1 Reset, door=1, level=3, startn pulse 1 cycle -> state=01 next edge, magnetron_on continuous,
//    timer_en=1; timer_done=1 -> magnetron_on=0, beep high 16 cycles, then state=00.
//  2 level=0, run 24 cycles -> magnetron_on pattern 2 on/6 off repeated 3x; level=2 -> 6 on/2 off.
//  3 RUN, door_closed=0 -> PAUSE, magnetron_on=0, timer_en=0; close door + startn edge -> RUN,
//    phase restarts at 0; stopn edge -> PAUSE, second stopn edge -> IDLE.
//  4 startn held low with door open, then door closes -> stays IDLE; timer_done=1 + start -> IDLE;
//    clearn=0 + start same cycle -> IDLE.
//  5 Simultaneous stop_evt & timer_done in RUN -> PAUSE (stop wins); clearn=0 in DONE -> beep=0, IDLE.
//  6 resetn=0 mid-RUN asynchronously -> all outputs 0 before next clk edge; power_level=3 with
//    LEVELS=3 (LVL_W=2) -> clamped, 8 on/0 off at PERIOD=8... on_cycles=8.

Source files
------------

// File: rtl/magnetron_control.sv
// rtl/magnetron_control.sv - magnetron power/duty controller with pause, resume and end-of-cook beep
module magnetron_control #(
    parameter int LEVELS      = 4,
    parameter int PERIOD      = 8,
    parameter int BEEP_CYCLES = 16,
    parameter int LVL_W       = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    input  logic             timer_done,
    input  logic [LVL_W-1:0] power_level,
    output logic             magnetron_on,
    output logic             timer_en,
    output logic             beep,
    output logic [1:0]       state
);

    localparam int PH_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int BC_W = $clog2(BEEP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic [BC_W-1:0]   beep_q, beep_d;
    logic              startn_q, stopn_q;
    logic              start_evt, stop_evt, go;

    // Out-of-range requests run at the highest level rather than wrapping.
    function automatic logic [LVL_W-1:0] clamp_level(input logic [LVL_W-1:0] p);
        if (int'(p) >= LEVELS) begin
            return LVL_W'(LEVELS - 1);
        end
        return p;
    endfunction

    function automatic int on_cycles(input logic [LVL_W-1:0] l);
        return ((int'(l) + 1) * PERIOD) / LEVELS;
    endfunction

    assign start_evt = ~startn & startn_q;
    assign stop_evt  = ~stopn & stopn_q;
    // A start only counts when nothing of higher priority is present on the same edge.
    assign go        = clearn & ~stop_evt & start_evt & door_closed & ~timer_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            lvl_q    <= '0;
            beep_q   <= '0;
            startn_q <= 1'b1;
            stopn_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            lvl_q    <= lvl_d;
            beep_q   <= beep_d;
            startn_q <= startn;
            stopn_q  <= stopn;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        lvl_d   = lvl_q;
        beep_d  = beep_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = RUN;
                    phase_d = '0;
                    lvl_d   = clamp_level(power_level);
                end
            end
            RUN: begin
                if (!clearn) begin
                    state_d = IDLE;
                end else if (stop_evt) begin
                    state_d = PAUSE;
                end else if (timer_done) begin
                    state_d = DONE;
                    beep_d  = BC_W'(BEEP_CYCLES);
                end else if (!door_closed) begin
                    state_d = PAUSE;
                end else begin
                    phase_d = (phase_q == PH_W'(PERIOD - 1)) ? '0 : phase_q + 1'b1;
                end
            end
            PAUSE: begin
                if (!clearn || stop_evt) begin
                    state_d = IDLE;
                end else if (go) begin
                    state_d = RUN;
                    phase_d = '0;
                    lvl_d   = clamp_level(power_level);
                end
            end
            DONE: begin
                if (!clearn || beep_q <= BC_W'(1)) begin
                    state_d = IDLE;
                    beep_d  = '0;
                end else begin
                    beep_d = beep_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign magnetron_on = (state_q == RUN) && (int'(phase_q) < on_cycles(lvl_q));
    assign timer_en     = (state_q == RUN);
    assign beep         = (state_q == DONE);
    assign state        = state_q;

endmodule

// File: tb/tb_magnetron_control.sv
// tb/tb_magnetron_control.sv - directed and random checks of magnetron_control against a cycle-count model
module tb_magnetron_control;

    localparam int PERIOD = 8;
    localparam int BC     = 16;

    logic       clk = 1'b0;
    logic       resetn, startn, stopn, clearn, door_closed, timer_done;
    logic [1:0] power_level;
    logic       mag0, ten0, beep0, mag1, ten1, beep1;
    logic [1:0] st0, st1;

    magnetron_control u0 (
        .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .timer_done(timer_done), .power_level(power_level),
        .magnetron_on(mag0), .timer_en(ten0), .beep(beep0), .state(st0)
    );

    magnetron_control #(.LEVELS(3), .PERIOD(8), .BEEP_CYCLES(16), .LVL_W(2)) u1 (
        .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .timer_done(timer_done), .power_level(power_level),
        .magnetron_on(mag1), .timer_en(ten1), .beep(beep1), .state(st1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: state code, cycles since RUN entry, level, cycles spent in DONE.
    int ms[2], mrun[2], mlvl[2], mdone[2];
    int lv[2] = '{4, 3};
    logic p_start, p_stop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0; mrun[i] = 0; mlvl[i] = 0; mdone[i] = 0;
        end
        p_start = 1'b1;
        p_stop  = 1'b1;
    endtask

    task automatic model_step();
        bit se, pe, go;
        int pl;
        if (!resetn) begin
            model_reset();
            return;
        end
        se = !startn && p_start;
        pe = !stopn && p_stop;
        go = clearn && !pe && se && door_closed && !timer_done;
        pl = int'(power_level);
        for (int i = 0; i < 2; i++) begin
            case (ms[i])
                0: if (go) begin ms[i] = 1; mrun[i] = 0; mlvl[i] = (pl >= lv[i]) ? lv[i] - 1 : pl; end
                1: begin
                    if (!clearn) ms[i] = 0;
                    else if (pe) ms[i] = 2;
                    else if (timer_done) begin ms[i] = 3; mdone[i] = 0; end
                    else if (!door_closed) ms[i] = 2;
                    else mrun[i]++;
                end
                2: begin
                    if (!clearn || pe) ms[i] = 0;
                    else if (go) begin ms[i] = 1; mrun[i] = 0; mlvl[i] = (pl >= lv[i]) ? lv[i] - 1 : pl; end
                end
                default: begin
                    if (!clearn) ms[i] = 0;
                    else begin
                        mdone[i]++;
                        if (mdone[i] >= BC) ms[i] = 0;
                    end
                end
            endcase
        end
        p_start = startn;
        p_stop  = stopn;
    endtask

    function automatic logic exp_mag(input int i);
        return (ms[i] == 1) && ((mrun[i] % PERIOD) < ((mlvl[i] + 1) * PERIOD) / lv[i]);
    endfunction

    task automatic compare();
        chk("state_u0", st0, ms[0]);
        chk("mag_u0", mag0, exp_mag(0));
        chk("ten_u0", ten0, ms[0] == 1);
        chk("beep_u0", beep0, ms[0] == 3);
        chk("state_u1", st1, ms[1]);
        chk("mag_u1", mag1, exp_mag(1));
        chk("ten_u1", ten1, ms[1] == 1);
        chk("beep_u1", beep1, ms[1] == 3);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        #3;
        compare();
    endtask

    task automatic start_pulse();
        startn = 1'b0;
        cyc();
        startn = 1'b1;
    endtask

    int on0, on1, nb;

    initial begin
        resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; timer_done = 1'b0; power_level = 2'd3;
        model_reset();
        #1;
        chk("rst_state", st0, 0);
        chk("rst_mag", mag0, 0);
        chk("rst_ten", ten0, 0);
        chk("rst_beep", beep0, 0);
        cyc(); cyc();
        resetn = 1'b1;
        cyc();

        // full power, then timer completion and beep
        start_pulse();
        chk("t1_run", st0, 1);
        on0 = 0;
        for (int k = 0; k < 8; k++) begin on0 += int'(mag0); cyc(); end
        chk("t1_on_full", on0, 8);
        chk("t1_ten", ten0, 1);
        timer_done = 1'b1; cyc(); timer_done = 1'b0;
        chk("t1_done", st0, 3);
        chk("t1_mag_off", mag0, 0);
        nb = 0;
        for (int k = 0; k < 20; k++) begin nb += int'(beep0); cyc(); end
        chk("t1_beep_len", nb, 16);
        chk("t1_idle", st0, 0);

        // duty patterns
        power_level = 2'd0;
        start_pulse();
        on0 = 0;
        for (int k = 0; k < 24; k++) begin
            if (k < 8) chk("t2_l0_pat", mag0, (k < 2));
            on0 += int'(mag0); cyc();
        end
        chk("t2_l0_on", on0, 6);
        clearn = 1'b0; cyc(); clearn = 1'b1;
        chk("t2_clear", st0, 0);
        power_level = 2'd2;
        start_pulse();
        on0 = 0; on1 = 0;
        for (int k = 0; k < 8; k++) begin on0 += int'(mag0); on1 += int'(mag1); cyc(); end
        chk("t2_l2_on", on0, 6);
        chk("t2_l2_on_u1", on1, 8);

        // door pause, resume, stop/stop cancel
        door_closed = 1'b0; cyc();
        chk("t3_pause", st0, 2);
        chk("t3_mag", mag0, 0);
        chk("t3_ten", ten0, 0);
        door_closed = 1'b1;
        start_pulse();
        chk("t3_resume", st0, 1);
        chk("t3_phase0", mag0, 1);
        stopn = 1'b0; cyc(); stopn = 1'b1;
        chk("t3_stop", st0, 2);
        cyc();
        stopn = 1'b0; cyc(); stopn = 1'b1;
        chk("t3_cancel", st0, 0);

        // held start, blocked starts
        startn = 1'b0; door_closed = 1'b0;
        cyc(); cyc(); cyc();
        door_closed = 1'b1;
        cyc(); cyc(); cyc();
        chk("t4_held", st0, 0);
        startn = 1'b1; cyc();
        timer_done = 1'b1; start_pulse(); timer_done = 1'b0;
        chk("t4_td_start", st0, 0);
        clearn = 1'b0; start_pulse(); clearn = 1'b1;
        chk("t4_clr_start", st0, 0);
        cyc();

        // stop beats timer_done; clear in DONE
        start_pulse(); cyc();
        stopn = 1'b0; timer_done = 1'b1; cyc(); stopn = 1'b1; timer_done = 1'b0;
        chk("t5_stop_wins", st0, 2);
        cyc();
        start_pulse();
        timer_done = 1'b1; cyc(); timer_done = 1'b0;
        chk("t5_done", st0, 3);
        cyc(); cyc();
        clearn = 1'b0; cyc(); clearn = 1'b1;
        chk("t5_clr_state", st0, 0);
        chk("t5_clr_beep", beep0, 0);

        // async reset mid-RUN
        power_level = 2'd3;
        start_pulse(); cyc();
        resetn = 1'b0;
        #1;
        chk("t6_rst_mag", mag0, 0);
        chk("t6_rst_ten", ten0, 0);
        chk("t6_rst_state", st0, 0);
        chk("t6_rst_beep", beep0, 0);
        model_reset();
        cyc();
        resetn = 1'b1;
        cyc();

        // clamp on 3-level instance
        start_pulse();
        chk("t6_u1_run", st1, 1);
        on1 = 0;
        for (int k = 0; k < 8; k++) begin on1 += int'(mag1); cyc(); end
        chk("t6_clamp_on", on1, 8);
        clearn = 1'b0; cyc(); clearn = 1'b1;

        // random traffic
        for (int k = 0; k < 4000; k++) begin
            startn      = ($urandom_range(0, 3) != 0);
            stopn       = ($urandom_range(0, 11) != 0);
            clearn      = ($urandom_range(0, 63) != 0);
            door_closed = ($urandom_range(0, 15) != 0);
            timer_done  = ($urandom_range(0, 40) == 0);
            power_level = 2'($urandom_range(0, 3));
            resetn      = ($urandom_range(0, 499) != 0);
            cyc();
        end
        resetn = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
